// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encodings and widths.
// Pure declarations, no timing or flow-control behaviour of its own.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Index width for an N-entry selector; stays 1 bit wide even for degenerate N.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port bundle seen by the arbiter.
// The master modport is the arbiter; the slave modport is producers and FIFO together.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DEFAULT_DATA_W
);
  localparam int IW = idx_w(N);

  logic [N-1:0]        req_valid;
  logic [N*DATA_W-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic                fifo_full;
  logic                fifo_wr_en;
  logic [DATA_W-1:0]   fifo_din;
  logic [IW-1:0]       grant_id;
  logic                busy;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping modulo N.
// Purely combinational, no backpressure.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    // k == N revisits 'last' itself, so a lone requester keeps winning.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the FIFO write port; one grantee for up to BURST beats, one idle bubble between grants.
// Valid seen at t is writable at t+1; fifo_full stalls the grantee without losing its grant or beat count.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BURST  = 4
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int IW = idx_w(N);
  localparam int CW = $clog2(BURST + 1);

  state_t            state;
  logic [IW-1:0]     grant_id;
  logic [IW-1:0]     last;
  logic [CW-1:0]     beat_cnt;
  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic              busy;
  logic              cur_vld;
  logic              open;
  logic              accept;
  logic [DATA_W-1:0] data_arr [N];

  rr_pick #(.N(N)) u_pick (
    .req  (bus.req_valid),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  assign busy    = (state == ST_GRANT);
  assign cur_vld = bus.req_valid[grant_id];
  // Gating on rst_n keeps a beat from being handed over in the cycle the grant is torn down.
  assign open    = busy && rst_n && !bus.fifo_full;
  assign accept  = open && cur_vld;

  assign bus.req_ready  = open ? (N'(1) << grant_id) : '0;
  assign bus.fifo_wr_en = accept;
  assign bus.fifo_din   = busy ? data_arr[grant_id] : '0;
  assign bus.grant_id   = grant_id;
  assign bus.busy       = busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      last     <= IW'(N - 1);
      grant_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!cur_vld) begin
            last  <= grant_id;
            state <= ST_IDLE;
          end else if (accept) begin
            if (beat_cnt == CW'(BURST - 1)) begin
              last     <= grant_id;
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
